control_bounded_modulator_fix: RTL and testbench
================================================

// Module: control_bounded_modulator_fix
// PURPOSE
// - Fixed-point digital model of the chain-of-integrators control-bounded ADC front end.
// - Generates the M=N control-bit stream, one vector per clk, that the hybrid fixed-point filter consumes on its `in` port.
// - Used for closed-loop simulation and on-chip self-test: a digital sample goes in, the filter's control bits come out.
// PARAMETERS
// - N         4    number of integrator stages (= control bits M)
// - IN_WIDTH  14   input sample width, signed Q0.(IN_WIDTH-1); must satisfy n_mant >= IN_WIDTH-1
// - n_int     4    integer bits of each integrator state
// - n_mant    15   fractional bits of each integrator state; state width W = n_int+n_mant+1
// - G_SHIFT   3    integrator gain = 2^-G_SHIFT, applied as an arithmetic right shift
// - SETTLE    16   cycles spent in SETTLE before valid asserts (>=1)
// PORTS
// - clk           in   1         single clock; all state updates on posedge clk
// - rst           in   1         asynchronous, active-low reset
// - en            in   1         1 = run modulator; 0 = return to IDLE and clear state
// - sample        in   IN_WIDTH  signed input u, Q0.(IN_WIDTH-1)
// - sample_valid  in   1         load sample into hold register this cycle
// - out           out  N         control bits s[N-1:0]; s_k=1 means b_k=+1, s_k=0 means b_k=-1
// - valid         out  1         out is a settled control stream
// - overload      out  1         sticky flag: an integrator saturated
// BEHAVIOUR
// - Reset (rst=0, async): clears state to IDLE; out=0, valid=0, overload=0; x_k=0, hold=0, settle count=0.
// - Hold register: on posedge with sample_valid=1, hold <= sample, independent of FSM state.
//   - Alignment: u = sign-extended hold << (n_mant-IN_WIDTH+1).
// - Kappa = 1.0, i.e. 2^n_mant LSB; b_k*kappa = +/-2^n_mant.
// - Update (SETTLE and RUN, every clk), computed at full precision W+2 bits, then saturated:
//   - x_0 <= sat(x_0 + ((u - b_0*kappa) >>> G_SHIFT))
//   - x_k <= sat(x_k + ((x_{k-1} - b_k*kappa) >>> G_SHIFT)), for k = 1..N-1
//   - All terms use current-cycle register values: old x_{k-1} and old s.
//   - Arithmetic shift rounds toward -inf by truncation.
// - Quantiser: s_k <= ~x_k[W-1], from the pre-update x_k (x_k >= 0 gives 1); out = s.
// - Saturation range: [-2^(W-1), 2^(W-1)-1] LSB.
//   - Any clamp in a cycle sets overload on that edge; it stays set until IDLE or reset.
// - Latency:
//   - sample_valid edge: hold updates.
//   - Next edge: x_0 reflects the new hold.
//   - Edge after that: s_0 reflects it.
// - FSM:
//   - IDLE:
//     - Entry: x=0, s=0, valid=0, overload cleared, count=0.
//     - en=1 moves to SETTLE on the next edge.
//   - SETTLE:
//     - Integrates; count increments each cycle.
//     - When count==SETTLE-1 and en=1, moves to RUN.
//   - RUN:
//     - Integrates; valid=1 registered, i.e. valid rises on the edge entering RUN.
//   - en=0 in SETTLE/RUN: next edge goes to IDLE.
//     - valid=0, x and s cleared, count cleared, overload cleared, all on that same edge.
//   - en=0 in IDLE: stays IDLE; only the hold register is live.
// - Simultaneous events:
//   - sample_valid together with the en 1->0 edge: hold still loads.
//   - Saturation on the same edge that leaves RUN: overload stays 0, because the clear wins.
// - Reset mid-RUN: immediate clear. After release, the block needs en high (or held high) to pass through SETTLE again.
// TESTING
// - rst pulsed low mid-RUN, asynchronous to clk -> out=0, valid=0, overload=0 before the next edge; after release with en=1, valid returns exactly SETTLE+1 edges later.
// - Defaults, sample=0 held, en=1 -> valid after SETTLE+1 edges; over 1024 RUN cycles, count of out[0]=1 is 512+/-4; overload=0.
// - sample=0x1000 (+0.5) -> over 4096 RUN cycles, out[0] ones count is 3072+/-8 (p=(1+u)/2); overload=0.
// - N=2, n_int=1, G_SHIFT=0, sample=-8192 (-1.0) -> overload=1 within 8 edges; stays 1 after sample returns to 0; clears only on the edge after en=0.
// - en dropped for 1 cycle mid-RUN -> valid=0 on the next edge, all x_k=0; full SETTLE re-run before valid=1 again.
// - sample_valid pulsed with 0x0800, then held low while sample toggles randomly -> behaviour identical to a constant 0x0800 input; hold reaches x_0 one edge after the pulse edge.

Source files
------------

// File: rtl/control_bounded_modulator_fix.sv
// control_bounded_modulator_fix: fixed-point chain-of-integrators control-bounded modulator
module control_bounded_modulator_fix #(
   parameter int N        = 4,
   parameter int IN_WIDTH = 14,
   parameter int n_int    = 4,
   parameter int n_mant   = 15,
   parameter int G_SHIFT  = 3,
   parameter int SETTLE   = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic signed [IN_WIDTH-1:0] sample,
   input  logic                       sample_valid,
   output logic [N-1:0]               out,
   output logic                       valid,
   output logic                       overload
);
   localparam int W  = n_int + n_mant + 1;
   localparam int E  = W + 2;
   localparam int CW = $clog2(SETTLE + 1);
   localparam logic signed [E-1:0] KAPPA = E'(2 ** n_mant);
   localparam logic signed [E-1:0] XMAX  = E'(2 ** (W - 1) - 1);
   localparam logic signed [E-1:0] XMIN  = E'(-(2 ** (W - 1)));

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_RUN} state_t;

   state_t                     state, state_nx;
   logic signed [IN_WIDTH-1:0] hold;
   logic signed [W-1:0]        u;
   logic signed [W-1:0]        x [N];
   logic signed [W-1:0]        x_next [N];
   logic [N-1:0]               s, clamp;
   logic [CW-1:0]              count;
   logic                       active;

   assign u      = {{(W - IN_WIDTH){hold[IN_WIDTH-1]}}, hold} << (n_mant - IN_WIDTH + 1);
   assign active = en && (state != ST_IDLE);
   assign out    = s;

   for (genvar k = 0; k < N; k++) begin : g_stage
      logic signed [E-1:0] a, d, t;
      if (k == 0) begin : g_head
         assign a = {{2{u[W-1]}}, u};
      end else begin : g_chain
         assign a = {{2{x[k-1][W-1]}}, x[k-1]};
      end
      assign d         = (a - (s[k] ? KAPPA : -KAPPA)) >>> G_SHIFT;
      assign t         = {{2{x[k][W-1]}}, x[k]} + d;
      assign clamp[k]  = (t > XMAX) || (t < XMIN);
      assign x_next[k] = (t > XMAX) ? XMAX[W-1:0] : (t < XMIN) ? XMIN[W-1:0] : t[W-1:0];
   end

   // next state: en low always returns to IDLE, otherwise IDLE -> SETTLE -> RUN
   always_comb begin
      state_nx = !en ? ST_IDLE :
                 (state == ST_IDLE) ? ST_SETTLE :
                 (state == ST_SETTLE && count == CW'(SETTLE - 1)) ? ST_RUN : state;
   end

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nx;
   end

   // hold register is always live; integrators, quantiser and flags run only while active
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold     <= '0;
         x        <= '{default: '0};
         s        <= '0;
         count    <= '0;
         valid    <= 1'b0;
         overload <= 1'b0;
      end else begin
         if (sample_valid) hold <= sample;
         if (active) begin
            x <= x_next;
            for (int k = 0; k < N; k++) s[k] <= ~x[k][W-1];
            count    <= (state == ST_SETTLE) ? count + 1'b1 : count;
            valid    <= (state_nx == ST_RUN);
            overload <= overload | (|clamp);
         end else begin
            x        <= '{default: '0};
            s        <= '0;
            count    <= '0;
            valid    <= 1'b0;
            overload <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_control_bounded_modulator_fix.sv
// tb_control_bounded_modulator_fix: scoreboard bench with an arithmetic reference model
module tb_control_bounded_modulator_fix;
   localparam int SETTLE = 16;
   localparam int MANT   = 15;
   localparam int IW     = 14;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en_a = 1'b0, sv_a = 1'b0, en_b = 1'b0, sv_b = 1'b0;
   logic signed [IW-1:0] sample_a = '0, sample_b = '0;
   logic [3:0] out_a;
   logic [1:0] out_b;
   logic valid_a, overload_a, valid_b, overload_b;

   int checks = 0, errors = 0;

   longint mx [2][4];
   bit     ms [2][4];
   longint mh [2];
   int     mc [2];
   bit     mo [2];
   int     pn   [2] = '{4, 2};
   int     pint [2] = '{4, 1};
   int     pg   [2] = '{3, 0};
   logic [5:0] q0 [$];
   logic [5:0] q1 [$];

   control_bounded_modulator_fix dut_a (
      .clk(clk), .rst(rst), .en(en_a), .sample(sample_a), .sample_valid(sv_a),
      .out(out_a), .valid(valid_a), .overload(overload_a));

   control_bounded_modulator_fix #(.N(2), .n_int(1), .G_SHIFT(0)) dut_b (
      .clk(clk), .rst(rst), .en(en_b), .sample(sample_b), .sample_valid(sv_b),
      .out(out_b), .valid(valid_b), .overload(overload_b));

   always #5 clk = ~clk;

   function automatic longint fdiv(longint a, longint m);
      return (a >= 0) ? a / m : -((-a + m - 1) / m);
   endfunction

   // one clock edge of the reference: integration uses values from before the edge
   task automatic step(int i, bit en, bit sv, longint smp);
      longint hi, lo, a, t;
      longint nx [4];
      bit     ns [4];
      hi = (longint'(1) << (pint[i] + MANT)) - 1;
      lo = -hi - 1;
      if (!en) begin
         for (int k = 0; k < 4; k++) begin
            mx[i][k] = 0;
            ms[i][k] = 0;
         end
         mc[i] = 0;
         mo[i] = 0;
      end else if (mc[i] == 0) begin
         mc[i] = 1;
      end else begin
         for (int k = 0; k < pn[i]; k++) begin
            if (k == 0) a = mh[i] * (longint'(1) << (MANT - IW + 1));
            else        a = mx[i][k-1];
            t = mx[i][k] + fdiv(a - (ms[i][k] ? 1 : -1) * (longint'(1) << MANT), longint'(1) << pg[i]);
            if (t > hi || t < lo) mo[i] = 1;
            nx[k] = (t > hi) ? hi : (t < lo) ? lo : t;
            ns[k] = (mx[i][k] >= 0);
         end
         for (int k = 0; k < pn[i]; k++) begin
            mx[i][k] = nx[k];
            ms[i][k] = ns[k];
         end
         if (mc[i] <= SETTLE) mc[i]++;
      end
      if (sv) mh[i] = smp;
   endtask

   function automatic logic [5:0] expv(int i);
      logic [3:0] o;
      o = '0;
      for (int k = 0; k < pn[i]; k++) o[k] = ms[i][k];
      return {mc[i] > SETTLE, mo[i], o};
   endfunction

   task automatic chk(string nm, logic [5:0] act, logic [5:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %b want %b at %0t", nm, act, req, $time);
      end
   endtask

   task automatic chk_range(string nm, int act, int lo, int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s got %0d want %0d..%0d at %0t", nm, act, lo, hi, $time);
      end
   endtask

   task automatic tick(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic count_ones(int n, output int c);
      c = 0;
      repeat (n) begin
         @(negedge clk);
         c += int'(out_a[0]);
      end
   endtask

   // reference model: steps on every edge and pushes the expected post-edge outputs
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) begin
               mx[i][k] = 0;
               ms[i][k] = 0;
            end
            mh[i] = 0;
            mc[i] = 0;
            mo[i] = 0;
         end
         q0.delete();
         q1.delete();
      end else begin
         step(0, en_a, sv_a, sample_a);
         step(1, en_b, sv_b, sample_b);
         q0.push_back(expv(0));
         q1.push_back(expv(1));
      end
   end

   // monitor: compare each presented output vector against the scoreboard
   always @(negedge clk) begin
      if (q0.size() > 0) chk("stream_a", {valid_a, overload_a, out_a}, q0.pop_front());
      if (q1.size() > 0) chk("stream_b", {valid_b, overload_b, 2'b00, out_b}, q1.pop_front());
   end

   initial begin
      int c, n;
      #2 rst = 1'b0;
      #6;
      chk("reset_a", {valid_a, overload_a, out_a}, 6'b0);
      chk("reset_b", {valid_b, overload_b, 2'b00, out_b}, 6'b0);
      #15 rst = 1'b1;

      sample_a = '0; sv_a = 1'b1; en_a = 1'b1;
      tick();
      sv_a = 1'b0;
      tick(SETTLE + 4);
      count_ones(1024, c);
      chk_range("ones_u0", c, 508, 516);

      sample_a = 14'sh1000; sv_a = 1'b1;
      tick();
      sv_a = 1'b0;
      tick(64);
      count_ones(4096, c);
      chk_range("ones_u_half", c, 3064, 3080);

      tick();
      en_a = 1'b0;
      tick();
      chk_range("valid_after_drop", int'(valid_a), 0, 0);
      en_a = 1'b1;
      tick(SETTLE + 5);

      sample_a = 14'sh0800; sv_a = 1'b1;
      tick();
      sv_a = 1'b0;
      repeat (200) begin
         sample_a = 14'($urandom);
         tick();
      end

      repeat (2000) begin
         sample_a = 14'($urandom);
         sv_a = ($urandom_range(3) == 0);
         en_a = ($urandom_range(199) != 0);
         tick();
      end

      en_a = 1'b1; sv_a = 1'b0;
      tick(SETTLE + 4);
      #2 rst = 1'b0;
      #1 chk("rst_async", {valid_a, overload_a, out_a}, 6'b0);
      #3 rst = 1'b1;
      n = 0;
      while (!valid_a && n < 40) begin
         @(posedge clk);
         #1 n++;
      end
      chk_range("valid_latency", n, SETTLE + 1, SETTLE + 1);

      en_a = 1'b0;
      sample_b = -14'sd8192; sv_b = 1'b1; en_b = 1'b1;
      tick();
      sv_b = 1'b0;
      n = 0;
      while (!overload_b && n < SETTLE + 10) begin
         @(posedge clk);
         #1 n++;
      end
      chk_range("ovl_rise_edges", n, 1, 8);
      sample_b = '0; sv_b = 1'b1;
      tick();
      sv_b = 1'b0;
      tick(50);
      chk_range("ovl_sticky", int'(overload_b), 1, 1);
      en_b = 1'b0;
      tick();
      chk_range("ovl_clear", int'(overload_b), 0, 0);

      tick(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
